cache_controller: RTL and testbench
===================================

# cache_controller

Two-way set-associative, write-through, read-allocate data cache between the MEM stage and the SRAM controller. Read hits return data in the same cycle. Read misses and all writes are forwarded to the SRAM controller over its enable/ready handshake. `readyOut` freezes the pipeline while an SRAM transaction is outstanding.

## Interface
Parameters:
- `SETS`, 64: number of sets; index width is log2(SETS) = 6.
- `TAG_W`, 11: tag width, taken from memAddr[18:8].
- `BASE_ADDR`, 1024: data-memory base address, subtracted before indexing.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `wrEnIn`  in  1  store request from MEM stage.
- `rdEnIn`  in  1  load request from MEM stage.
- `addressIn`  in  32  byte address, word aligned.
- `writeDataIn`  in  32  store data.
- `readDataOut`  out  32  load data; valid when `readyOut`=1 and `rdEnIn`=1.
- `readyOut`  out  1  1 = request complete or no request; 0 = freeze pipeline.
- `sramWrEnOut`  out  1  write request to SRAM controller.
- `sramRdEnOut`  out  1  read request to SRAM controller.
- `sramAddressOut`  out  32  `addressIn` forwarded unchanged.
- `sramWriteDataOut`  out  32  `writeDataIn` forwarded unchanged.
- `sramReadDataIn`  in  32  word returned by SRAM controller.
- `sramReadyIn`  in  1  SRAM controller completion, combinational from its state.

## Operation
Address decode:
- memAddr = addressIn − BASE_ADDR (32-bit, wraps).
- set = memAddr[7:2]; tag = memAddr[18:8]; memAddr[1:0] ignored.

Storage:
- Per set: way0 and way1, each holding {valid, tag[10:0], data[31:0]}.
- One LRU bit per set; LRU=0 means way0 is least recently used.

Hit rule:
- hit = (valid & tag match) in way0 or way1.
- Both ways matching is impossible by construction.

FSM states (IDLE, READ_MISS, WRITE):
- IDLE, `wrEnIn`=1 → WRITE. Write has priority if `wrEnIn` and `rdEnIn` are both 1.
- IDLE, `rdEnIn`=1 with hit → stay in IDLE.
  - `readDataOut` = hit way data.
  - `readyOut` = 1.
  - LRU points to the other way.
- IDLE, `rdEnIn`=1 with miss → READ_MISS.
- IDLE, no request → IDLE, `readyOut`=1.
- READ_MISS: `sramRdEnOut`=1 while waiting.
  - `sramReadyIn` is sampled only in this state and WRITE; its value in other states is ignored, because the SRAM controller reports ready when idle.
  - On `sramReadyIn`=1: fill the victim way with {1, tag, `sramReadDataIn`}.
  - Victim selection: way0 if invalid, else way1 if invalid, else the LRU way.
  - LRU then points away from the victim.
  - `readDataOut` = `sramReadDataIn`, `readyOut`=1 that cycle, → IDLE.
- WRITE: `sramWrEnOut`=1 while waiting.
  - On `sramReadyIn`=1: if hit, update that way's data and LRU; if miss, no allocation.
  - `readyOut`=1 that cycle, → IDLE.

Default outputs:
- `readyOut`=0 in READ_MISS and WRITE until `sramReadyIn`.
- `readyOut`=0 in IDLE when a miss or write is requested.
- `readDataOut`=0 when not returning data.

## Timing
Reset values:
- State IDLE.
- All valid and LRU bits 0.
- `sramRdEnOut`=`sramWrEnOut`=0.
- `readyOut`=1 when no request is pending.
- `readDataOut`=0.

Reset mid-transaction:
- SRAM enables drop immediately (asynchronous).
- All lines invalidated.
- A partially filled line is never marked valid.

Latency:
- Read hit: 0 extra cycles.
- Miss or write: 1 cycle (IDLE→state) + SRAM latency. With the current SRAM controller, `readyOut` rises in the 6th cycle after the request is first seen.

SRAM enables:
- Driven only from the state register, never from inputs in IDLE.
- Drop the cycle after `sramReadyIn`, so the SRAM controller returns to idle without re-triggering.

Request stability: the requester holds `addressIn`, `writeDataIn` and the enables stable until `readyOut`=1.

## Structure
- Shared package holds state encodings (IDLE=2'd0, READ_MISS=2'd1, WRITE=2'd2), `SETS`, `TAG_W` and `BASE_ADDR`.
- One sub-module, `cache_array`, holds the valid/tag/data/LRU storage.
  - Combinational lookup outputs: hit, hitWay, data, victimWay.
  - Synchronous fill/update port.
  - Asynchronous clear on `rst`.
- FSM and handshake logic live in `cache_controller`.

## Test plan
- After reset, read 0x400 → `sramRdEnOut` for 5 cycles; SRAM model returns 0xDEADBEEF → `readDataOut`=0xDEADBEEF, `readyOut` in cycle 6; a repeat read hits in the same cycle.
- Read 0x400, 0x800, 0xC00 (same set, tags 0/4/8) → third miss evicts the 0x400 line; re-reading 0x800 hits; re-reading 0x400 misses.
- Write 0x12345678 to cached 0x404 → `sramWrEnOut` asserted, `readyOut` after SRAM done; a later read of 0x404 hits and returns 0x12345678 with no SRAM access.
- Write to uncached 0x500 → no allocation; a following read of 0x500 misses.
- Assert `rst` during READ_MISS → enables go to 0 immediately; the same read afterwards misses.
- `wrEnIn`=`rdEnIn`=1 at 0x408 → WRITE path taken; no read allocation.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared constants and FSM encoding for the two-way write-through data cache.
package cache_controller_pkg;

  localparam int          SETS      = 64;
  localparam int          TAG_W     = 11;
  localparam logic [31:0] BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

endpackage

// File: rtl/cache_array.sv
// Two-way valid/tag/data storage with one LRU bit per set.
// Lookup is combinational; fills and updates land on the rising edge.
module cache_array #(
  parameter int NUM_SETS = 64,
  parameter int IDX_W    = 6,
  parameter int TAG_BITS = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    set,
  input  logic [TAG_BITS-1:0] tag,
  output logic                hit,
  output logic                hit_way,
  output logic [31:0]         data,
  output logic                victim_way,
  input  logic                upd_en,
  input  logic                upd_way,
  input  logic [31:0]         upd_data
);

  logic [NUM_SETS-1:0] valid0, valid1, lru;
  logic [TAG_BITS-1:0] tag0  [NUM_SETS];
  logic [TAG_BITS-1:0] tag1  [NUM_SETS];
  logic [31:0]         data0 [NUM_SETS];
  logic [31:0]         data1 [NUM_SETS];

  logic match0, match1;

  // Tag compare, hit-way data select and victim choice for the addressed set
  always_comb begin
    match0     = valid0[set] && (tag0[set] == tag);
    match1     = valid1[set] && (tag1[set] == tag);
    hit        = match0 | match1;
    hit_way    = match1;
    data       = match1 ? data1[set] : data0[set];
    // Fill empty ways in order before evicting; lru names the older way
    victim_way = !valid0[set] ? 1'b0 :
                 !valid1[set] ? 1'b1 : lru[set];
  end

  // Valid and LRU state: cleared asynchronously, touched way becomes MRU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (upd_en) begin
      if (upd_way) valid1[set] <= 1'b1;
      else         valid0[set] <= 1'b1;
      lru[set] <= ~upd_way;
    end
  end

  // Tag/data payload needs no reset; it is only observed through valid
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (upd_way) begin
        tag1[set]  <= tag;
        data1[set] <= upd_data;
      end else begin
        tag0[set]  <= tag;
        data0[set] <= upd_data;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative write-through, read-allocate cache between MEM
// stage and SRAM controller. Read hits complete combinationally; misses
// and all writes go through the SRAM enable/ready handshake.
module cache_controller #(
  parameter int          SETS      = cache_controller_pkg::SETS,
  parameter int          TAG_W     = cache_controller_pkg::TAG_W,
  parameter logic [31:0] BASE_ADDR = cache_controller_pkg::BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEnIn,
  input  logic        rdEnIn,
  input  logic [31:0] addressIn,
  input  logic [31:0] writeDataIn,
  output logic [31:0] readDataOut,
  output logic        readyOut,
  output logic        sramWrEnOut,
  output logic        sramRdEnOut,
  output logic [31:0] sramAddressOut,
  output logic [31:0] sramWriteDataOut,
  input  logic [31:0] sramReadDataIn,
  input  logic        sramReadyIn
);

  import cache_controller_pkg::state_t;
  import cache_controller_pkg::IDLE;
  import cache_controller_pkg::READ_MISS;
  import cache_controller_pkg::WRITE;

  localparam int IDX_W = $clog2(SETS);
  localparam int HI    = IDX_W + TAG_W + 1;

  state_t state;

  // Word-granular offset into data memory. The base is word aligned, so
  // dropping the byte-offset bits before subtracting loses no borrow.
  logic [IDX_W+TAG_W-1:0] mem_word;
  logic [IDX_W-1:0]       set;
  logic [TAG_W-1:0]       tag;

  assign mem_word = addressIn[HI:2] - BASE_ADDR[HI:2];
  assign set      = mem_word[IDX_W-1:0];
  assign tag      = mem_word[IDX_W +: TAG_W];

  logic        hit, hit_way, victim_way;
  logic [31:0] hit_data;
  logic        upd_en, upd_way;
  logic [31:0] upd_data;

  cache_array #(
    .NUM_SETS (SETS),
    .IDX_W    (IDX_W),
    .TAG_BITS (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .set        (set),
    .tag        (tag),
    .hit        (hit),
    .hit_way    (hit_way),
    .data       (hit_data),
    .victim_way (victim_way),
    .upd_en     (upd_en),
    .upd_way    (upd_way),
    .upd_data   (upd_data)
  );

  assign sramAddressOut   = addressIn;
  assign sramWriteDataOut = writeDataIn;

  // Handshake outputs and array update strobe for the current state
  always_comb begin
    readyOut    = 1'b1;
    readDataOut = '0;
    upd_en      = 1'b0;
    upd_way     = hit_way;
    upd_data    = writeDataIn;
    case (state)
      IDLE: begin
        if (wrEnIn) begin
          readyOut = 1'b0;
        end else if (rdEnIn) begin
          if (hit) begin
            // Rewrite the hit word in place so the way becomes MRU
            readDataOut = hit_data;
            upd_en      = 1'b1;
            upd_data    = hit_data;
          end else begin
            readyOut = 1'b0;
          end
        end
      end
      READ_MISS: begin
        readyOut = sramReadyIn;
        if (sramReadyIn) begin
          readDataOut = sramReadDataIn;
          upd_en      = 1'b1;
          upd_way     = victim_way;
          upd_data    = sramReadDataIn;
        end
      end
      WRITE: begin
        readyOut = sramReadyIn;
        // Write-through with no allocate: only an existing line is updated
        upd_en   = sramReadyIn & hit;
      end
      default: readyOut = 1'b1;
    endcase
  end

  // Request FSM; SRAM enables are registered so they never follow inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sramRdEnOut <= 1'b0;
      sramWrEnOut <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wrEnIn) begin
            state       <= WRITE;
            sramWrEnOut <= 1'b1;
          end else if (rdEnIn && !hit) begin
            state       <= READ_MISS;
            sramRdEnOut <= 1'b1;
          end
        end
        READ_MISS: begin
          if (sramReadyIn) begin
            state       <= IDLE;
            sramRdEnOut <= 1'b0;
          end
        end
        WRITE: begin
          if (sramReadyIn) begin
            state       <= IDLE;
            sramWrEnOut <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          sramRdEnOut <= 1'b0;
          sramWrEnOut <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios then randomized traffic,
// checked against an LRU-list cache model plus a flat reference memory.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEnIn, rdEnIn;
  logic [31:0] addressIn, writeDataIn;
  logic [31:0] readDataOut;
  logic        readyOut;
  logic        sramWrEnOut, sramRdEnOut;
  logic [31:0] sramAddressOut, sramWriteDataOut;
  logic [31:0] sramReadDataIn;
  logic        sramReadyIn;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk              (clk),
    .rst              (rst),
    .wrEnIn           (wrEnIn),
    .rdEnIn           (rdEnIn),
    .addressIn        (addressIn),
    .writeDataIn      (writeDataIn),
    .readDataOut      (readDataOut),
    .readyOut         (readyOut),
    .sramWrEnOut      (sramWrEnOut),
    .sramRdEnOut      (sramRdEnOut),
    .sramAddressOut   (sramAddressOut),
    .sramWriteDataOut (sramWriteDataOut),
    .sramReadDataIn   (sramReadDataIn),
    .sramReadyIn      (sramReadyIn)
  );

  function automatic logic [31:0] dflt(int i);
    return (i == 0) ? 32'hDEADBEEF : (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [11:0] widx(logic [31:0] a);
    return a[13:2] - 12'h100;
  endfunction

  // SRAM controller model: ready when idle, otherwise on the 5th enabled cycle
  logic [31:0] sram_mem [4096];
  bit          sram_init = 1'b0;
  int          cnt = 0;
  logic        sram_busy;
  logic [11:0] sidx;

  assign sram_busy      = sramRdEnOut | sramWrEnOut;
  assign sidx           = widx(sramAddressOut);
  assign sramReadyIn    = !sram_busy || (cnt == 4);
  assign sramReadDataIn = (sramRdEnOut && cnt == 4) ? sram_mem[sidx] : 32'h0;

  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= dflt(i);
      sram_init <= 1'b1;
    end
    if (sram_busy) begin
      if (cnt == 4) begin
        cnt <= 0;
        if (sramWrEnOut) sram_mem[sidx] <= sramWriteDataOut;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  // Reference: per-set recency list of cached tags (front = MRU), plus memory
  int unsigned tq [64][$];
  logic [31:0] ref_mem [4096];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) tq[s].delete();
  endtask

  // One MEM-stage request; entered and left just after a rising edge
  task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] m;
    int          s, pos, n, exp_lat, exp_rdc, exp_wrc, rdc, wrc;
    int unsigned t;
    bit          hit, done;
    logic [1:0]  first_en;
    logic [31:0] exp_data, got_data;
    m = a - 32'h400;
    s = int'(m[7:2]);
    t = int'(m[18:8]);
    pos = -1;
    for (int i = 0; i < tq[s].size(); i++) if (tq[s][i] == t) pos = i;
    hit = (pos >= 0);
    exp_data = 32'h0; exp_rdc = 0; exp_wrc = 0;
    if (wr) begin
      exp_lat = 6; exp_wrc = 5;
      ref_mem[widx(a)] = wd;
      if (hit) begin tq[s].delete(pos); tq[s].push_front(t); end
    end else begin
      exp_data = ref_mem[widx(a)];
      if (hit) begin
        exp_lat = 1;
        tq[s].delete(pos); tq[s].push_front(t);
      end else begin
        exp_lat = 6; exp_rdc = 5;
        if (tq[s].size() == 2) void'(tq[s].pop_back());
        tq[s].push_front(t);
      end
    end

    wrEnIn = wr; rdEnIn = rd; addressIn = a; writeDataIn = wd;
    n = 0; done = 1'b0; rdc = 0; wrc = 0; first_en = 2'b00; got_data = 32'h0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) first_en = {sramRdEnOut, sramWrEnOut};
      else begin rdc += int'(sramRdEnOut); wrc += int'(sramWrEnOut); end
      if (sram_busy) chk($sformatf("sram_addr@%h", a), sramAddressOut, a);
      if (readyOut) begin done = 1'b1; got_data = readDataOut; end
      @(posedge clk); #1;
    end
    chk($sformatf("latency@%h", a), done ? n : 999, exp_lat);
    chk($sformatf("rdata@%h", a), got_data, exp_data);
    chk($sformatf("en_first@%h", a), {30'd0, first_en}, 32'd0);
    chk($sformatf("rd_cycles@%h", a), rdc, exp_rdc);
    chk($sformatf("wr_cycles@%h", a), wrc, exp_wrc);
    wrEnIn = 1'b0; rdEnIn = 1'b0;
  endtask

  task automatic idle_check(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      chk("idle_outputs", {readyOut, sramRdEnOut, sramWrEnOut, readDataOut[28:0]},
          {1'b1, 2'b00, 29'd0});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit          w, r;
    int          k;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) ref_mem[i] = dflt(i);
    model_clear();
    rst = 1'b1; wrEnIn = 1'b0; rdEnIn = 1'b0; addressIn = 32'h400; writeDataIn = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, readyOut}, 32'd1);
    chk("reset_rdata", readDataOut, 32'h0);
    chk("reset_en", {30'd0, sramRdEnOut, sramWrEnOut}, 32'd0);
    @(posedge clk); #1;

    // Cold miss then repeat hit; 0x400 holds 0xDEADBEEF
    do_req(1'b0, 1'b1, 32'h400, 32'h0);
    do_req(1'b0, 1'b1, 32'h400, 32'h0);
    // Same set, three tags: third miss evicts the LRU line
    do_req(1'b0, 1'b1, 32'h800, 32'h0);
    do_req(1'b0, 1'b1, 32'hC00, 32'h0);
    do_req(1'b0, 1'b1, 32'h800, 32'h0);
    do_req(1'b0, 1'b1, 32'h400, 32'h0);
    // Write hit updates cached word, later read hits with new data
    do_req(1'b0, 1'b1, 32'h404, 32'h0);
    do_req(1'b1, 1'b0, 32'h404, 32'h12345678);
    do_req(1'b0, 1'b1, 32'h404, 32'h0);
    // Write miss does not allocate
    do_req(1'b1, 1'b0, 32'h500, 32'hCAFEF00D);
    do_req(1'b0, 1'b1, 32'h500, 32'h0);
    idle_check(2);

    // Reset while waiting on a read miss
    wrEnIn = 1'b0; rdEnIn = 1'b1; addressIn = 32'h600;
    repeat (3) @(negedge clk);
    chk("midreset_pre_rden", {31'd0, sramRdEnOut}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midreset_en_drop", {30'd0, sramRdEnOut, sramWrEnOut}, 32'd0);
    model_clear();
    @(posedge clk); #1;
    rdEnIn = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 1'b1, 32'h600, 32'h0);
    do_req(1'b0, 1'b1, 32'h400, 32'h0);

    // Simultaneous write and read: write wins, nothing allocated
    do_req(1'b1, 1'b1, 32'h408, 32'h0BADC0DE);
    do_req(1'b0, 1'b1, 32'h408, 32'h0);

    // Randomized traffic on a few sets with several competing tags
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 9));
      w = (k >= 6);
      r = (k < 6) || (k == 9);
      a = 32'h400 + ($urandom_range(0, 5) << 8) + ($urandom_range(0, 3) << 2);
      do_req(w, r, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle_check(int'($urandom_range(1, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
